ex_stage_md: RTL and testbench
==============================

# ex_stage_md

Parametrised execute stage for the 5-stage RV32 pipeline: successor to the non-forwarding EX stage. Adds operand forwarding muxes, a branch resolver on forwarded operands, and an iterative RV32M multiply/divide unit that stalls the pipeline while it runs. Sits between the ID/EX and EX/MEM pipeline registers; the hazard unit drives the forward selects and consumes `md_stall`.

## Interface
- `XLEN`, 32: datapath width; multiply/divide iteration count.
- `CNT_W`, $clog2(XLEN)+1: iteration counter width.

- `i_clk`  in  1  clock, rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `pc_e`, `instr_e`  in  XLEN / 32  PC and instruction in EX.
- `rs1_data_e`, `rs2_data_e`, `imm_out_e`  in  XLEN  register-file operands; immediate.
- `alu_data_m`  in  XLEN  EX/MEM ALU result (forward source).
- `wb_data_w`  in  XLEN  writeback data (forward source).
- `fwd_a_sel`, `fwd_b_sel`  in  2  00 regfile, 01 `alu_data_m`, 10 `wb_data_w`, 11 regfile.
- `opa_sel_e`, `opb_sel_e`, `br_un_e`  in  1  A: 0 rs1 / 1 PC; B: 0 rs2 / 1 imm; unsigned compare.
- `alu_op_e`  in  4  ALU opcode (existing encoding).
- `md_valid_e`  in  1  EX holds an M-extension op; `instr_e[14:12]` is funct3.
- `flush_e`  in  1  kill EX instruction.
- `alu_data_e`  out  XLEN  ALU result, or M result when `md_valid_e`.
- `store_data_e`  out  XLEN  forwarded rs2.
- `br_taken`  out  1  branch/jump taken.
- `md_stall`  out  1  hold IF/ID/EX; bubble EX/MEM.
- `md_illegal`  out  1  M op not supported in this build.

## Operation
- Forwarding: `fa`/`fb` = forwarded rs1/rs2 per selects; opA = opa_sel ? pc : fa; opB = opb_sel ? imm : fb.
- Branch: compare `fa` vs `fb` (signed unless `br_un_e`). Opcode 1100011: funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; `br_un_e` selects signedness. JAL/JALR always taken. Else 0.
- MD FSM states IDLE, CALC, DONE.
  - IDLE: `md_valid_e & ~flush_e` latches fa, fb, funct3. Divisor zero or signed MIN/-1 -> DONE; else CALC, count = 0.
  - CALC: one radix-2 step per cycle (shift-add multiply on magnitudes, restoring divide); count+1; at count = XLEN-1 -> DONE.
  - DONE: result drives `alu_data_e`; -> IDLE next edge.
- Results: MUL low XLEN; MULH/MULHSU/MULHU high XLEN of signed×signed / signed×unsigned / unsigned×unsigned 2·XLEN product. DIV/REM: signed, truncating toward zero, remainder takes dividend sign. Divide by zero: quotient all ones, remainder = dividend. MIN/-1: quotient MIN, remainder 0.
- `md_stall` = `md_valid_e & state≠DONE & ~flush_e & ~i_reset`.
- `flush_e` in any state -> IDLE next edge; partial result discarded.
- Latched operands are used during CALC; forward-select changes while stalled are ignored.
- Reset: state IDLE, counter 0, operand/accumulator registers 0. Combinational outputs follow inputs; `md_stall`, `md_illegal` 0 while `i_reset` high.

## Timing
- Non-MD ops, branch, forwarding: combinational, zero latency.
- Normal MD op entering EX in cycle 0: `md_stall` high cycles 0..XLEN, DONE in cycle XLEN+1 (stall low, result valid); advances at the end of cycle XLEN+1. Total XLEN+2 cycles in EX.
- Special-case divide: stall cycle 0 only; result valid cycle 1.
- Back-to-back MD ops: second sees IDLE the cycle after DONE; no extra bubble.
- Async reset mid-CALC: IDLE immediately; stall drops on assertion.

## Configuration
- `RV_M_DIV_EN` defined: DIV/DIVU/REM/REMU supported as above.
- Not defined: no divider logic. `md_valid_e` with funct3[2]=1 gives `alu_data_e`=0, `md_illegal`=1, `md_stall`=0, FSM stays IDLE. Multiply ops unchanged.

## Test plan
- Forwarding: rs1_data=5, alu_data_m=7, fwd_a_sel=01, ADD with rs2=3 -> alu_data_e=10; fwd_a_sel=10, wb_data_w=1 -> 4.
- Branch: BLT, fa=0xFFFFFFFF, fb=1 -> br_taken=1; BLTU same operands -> 0; JAL -> 1.
- MULH: 0x80000000 × 0x80000000 -> 0x40000000; stall exactly 33 cycles; result in cycle 33.
- DIV -7/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF in 2 cycles; DIV 0x80000000/-1 -> 0x80000000.
- flush_e at CALC count 10, then new MUL 3×4 -> prior op discarded, result 12 after 34 cycles; i_reset mid-CALC -> md_stall 0 immediately.
- Without `RV_M_DIV_EN`: DIVU -> md_illegal=1, alu_data_e=0, no stall; MUL 6×7 -> 42.

Source files
------------

// File: rtl/ex_stage_md.sv
// ---------------------------------------------------------------------------
// ex_stage_md : RV32 execute stage with operand forwarding, branch resolution
// and an iterative multiply/divide unit.
//
// Optional feature macro: RV_M_DIV_EN
//   defined     -> DIV/DIVU/REM/REMU run on the iterative restoring divider.
//   not defined -> no divider is built; an M op with funct3[2]=1 raises
//                  md_illegal, returns 0 and does not stall.
//
// Parameters
//   XLEN          datapath width, also the number of multiply/divide steps
//   CNT_W         iteration counter width
//
// Ports
//   i_clk, i_reset           clock (rising edge), async active-high reset
//   pc_e, instr_e            PC and instruction currently in EX
//   rs1_data_e, rs2_data_e   register-file operands
//   imm_out_e                decoded immediate
//   alu_data_m, wb_data_w    forwarding sources (EX/MEM result, WB data)
//   fwd_a_sel, fwd_b_sel     00/11 regfile, 01 alu_data_m, 10 wb_data_w
//   opa_sel_e, opb_sel_e     A: 0 rs1 / 1 PC ; B: 0 rs2 / 1 imm
//   br_un_e                  unsigned branch compare
//   alu_op_e                 ALU opcode: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU,
//                            5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass B,
//                            others give 0
//   md_valid_e               EX holds an M-extension op (funct3 = instr_e[14:12])
//   flush_e                  kill the EX instruction
//   alu_data_e               ALU result, or M result while md_valid_e
//   store_data_e             forwarded rs2
//   br_taken                 branch/jump taken
//   md_stall                 hold IF/ID/EX and bubble EX/MEM
//   md_illegal               M op not supported in this build
//   md_state_dbg             M unit FSM state: 0 IDLE, 1 CALC, 2 DONE
//
// Handshake: md_valid_e is the request; the op is held in EX while md_stall
// is high and the result on alu_data_e is consumed on the first rising edge
// with md_valid_e high and md_stall low. flush_e withdraws the request at any
// point and discards any partial result.
// ---------------------------------------------------------------------------
module ex_stage_md #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [XLEN-1:0]  pc_e,
  input  logic [31:0]      instr_e,
  input  logic [XLEN-1:0]  rs1_data_e,
  input  logic [XLEN-1:0]  rs2_data_e,
  input  logic [XLEN-1:0]  imm_out_e,
  input  logic [XLEN-1:0]  alu_data_m,
  input  logic [XLEN-1:0]  wb_data_w,
  input  logic [1:0]       fwd_a_sel,
  input  logic [1:0]       fwd_b_sel,
  input  logic             opa_sel_e,
  input  logic             opb_sel_e,
  input  logic             br_un_e,
  input  logic [3:0]       alu_op_e,
  input  logic             md_valid_e,
  input  logic             flush_e,
  output logic [XLEN-1:0]  alu_data_e,
  output logic [XLEN-1:0]  store_data_e,
  output logic             br_taken,
  output logic             md_stall,
  output logic             md_illegal,
  output logic [1:0]       md_state_dbg
);

  localparam int SH_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  // ---------------- forwarding and operand select ----------------
  logic [XLEN-1:0] fa, fb, op_a, op_b;

  always_comb begin
    unique case (fwd_a_sel)
      2'b01:   fa = alu_data_m;
      2'b10:   fa = wb_data_w;
      default: fa = rs1_data_e;
    endcase
    unique case (fwd_b_sel)
      2'b01:   fb = alu_data_m;
      2'b10:   fb = wb_data_w;
      default: fb = rs2_data_e;
    endcase
  end

  assign op_a         = opa_sel_e ? pc_e : fa;
  assign op_b         = opb_sel_e ? imm_out_e : fb;
  assign store_data_e = fb;

  // ---------------- ALU ----------------
  logic [XLEN-1:0] alu_res;
  logic [SH_W-1:0] shamt;

  assign shamt = op_b[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_op_e)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'd5:    alu_res = op_a ^ op_b;
      4'd6:    alu_res = op_a >> shamt;
      4'd7:    alu_res = $signed(op_a) >>> shamt;
      4'd8:    alu_res = op_a | op_b;
      4'd9:    alu_res = op_a & op_b;
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // ---------------- branch resolver (on forwarded operands) ----------------
  logic br_eq, br_lt;

  assign br_eq = (fa == fb);
  assign br_lt = br_un_e ? (fa < fb) : ($signed(fa) < $signed(fb));

  always_comb begin
    br_taken = 1'b0;
    case (instr_e[6:0])
      OPC_BRANCH: begin
        case (instr_e[14:12])
          3'b000:         br_taken = br_eq;
          3'b001:         br_taken = ~br_eq;
          3'b100, 3'b110: br_taken = br_lt;
          3'b101, 3'b111: br_taken = ~br_lt;
          default:        br_taken = 1'b0;
        endcase
      end
      OPC_JAL, OPC_JALR: br_taken = 1'b1;
      default:           br_taken = 1'b0;
    endcase
  end

  // ---------------- multiply/divide operand preparation ----------------
  logic [2:0]      md_f3;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            md_ill_raw, md_special, md_start;

  assign md_f3    = instr_e[14:12];
  // Signed dividend/multiplicand for MUL, MULH, MULHSU, DIV, REM.
  assign a_signed = (md_f3 != 3'b011) && (md_f3 != 3'b101) && (md_f3 != 3'b111);
  // Signed divisor/multiplier for MUL, MULH, DIV, REM.
  assign b_signed = (md_f3 == 3'b000) || (md_f3 == 3'b001) ||
                    (md_f3 == 3'b100) || (md_f3 == 3'b110);
  assign a_neg    = a_signed & fa[XLEN-1];
  assign b_neg    = b_signed & fb[XLEN-1];
  assign a_mag    = a_neg ? (~fa + 1'b1) : fa;
  assign b_mag    = b_neg ? (~fb + 1'b1) : fb;

`ifdef RV_M_DIV_EN
  logic div_zero, div_ovf;
  assign div_zero   = (fb == '0);
  assign div_ovf    = ~md_f3[0] && (fa == XMIN) && (fb == '1);
  assign md_special = md_f3[2] & (div_zero | div_ovf);
  assign md_ill_raw = 1'b0;
`else
  assign md_special = 1'b0;
  assign md_ill_raw = md_valid_e & md_f3[2];
`endif

  // ---------------- FSM: state register ----------------
  logic [1:0] state_q, state_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  assign md_start = (state_q == S_IDLE) & md_valid_e & ~flush_e & ~md_ill_raw;

  // ---------------- iteration datapath ----------------
  // prod_q: multiply -> {partial product high, remaining multiplier bits}
  //         divide   -> {partial remainder, dividend bits / quotient bits}
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   mag_q, mag_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;

  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                    (prod_q[0] ? {1'b0, mag_q} : {(XLEN+1){1'b0}});
  assign mul_step = {mul_sum, prod_q[XLEN-1:1]};

`ifdef RV_M_DIV_EN
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_step;

  assign div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mag_q};
  // Borrow out means the divisor did not fit: restore and shift in a 0.
  assign div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  prod_q[XLEN-2:0], 1'b1};
`endif

  always_comb begin
    cnt_d  = cnt_q;
    prod_d = prod_q;
    mag_d  = mag_q;
    f3_d   = f3_q;
    neg_d  = neg_q;
    if (md_start) begin
      cnt_d = '0;
      f3_d  = md_f3;
`ifdef RV_M_DIV_EN
      if (md_f3[2]) begin
        mag_d = b_mag;
        if (div_zero) begin
          // Quotient all ones, remainder = raw dividend, no sign fix-up.
          prod_d = {fa, {XLEN{1'b1}}};
          neg_d  = 1'b0;
        end else if (div_ovf) begin
          prod_d = {{XLEN{1'b0}}, XMIN};
          neg_d  = 1'b0;
        end else begin
          prod_d = {{XLEN{1'b0}}, a_mag};
          // Remainder follows the dividend sign, quotient the XOR of signs.
          neg_d  = md_f3[1] ? a_neg : (a_neg ^ b_neg);
        end
      end else
`endif
      begin
        prod_d = {{XLEN{1'b0}}, b_mag};
        mag_d  = a_mag;
        neg_d  = a_neg ^ b_neg;
      end
    end else if ((state_q == S_CALC) && !flush_e) begin
      cnt_d = cnt_q + 1'b1;
`ifdef RV_M_DIV_EN
      prod_d = f3_q[2] ? div_step : mul_step;
`else
      prod_d = mul_step;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q  <= '0;
      prod_q <= '0;
      mag_q  <= '0;
      f3_q   <= '0;
      neg_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
      mag_q  <= mag_d;
      f3_q   <= f3_d;
      neg_q  <= neg_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (md_start) state_d = md_special ? S_DONE : S_CALC;
      S_CALC: begin
        if (flush_e)                                state_d = S_IDLE;
        else if (cnt_q == CNT_W'(XLEN - 1))         state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   mul_res, md_result;

  assign prod_fix = neg_q ? (~prod_q + 1'b1) : prod_q;
  assign mul_res  = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

`ifdef RV_M_DIV_EN
  logic [XLEN-1:0] div_raw, div_res;
  assign div_raw   = f3_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
  assign div_res   = neg_q ? (~div_raw + 1'b1) : div_raw;
  assign md_result = f3_q[2] ? div_res : mul_res;
`else
  assign md_result = mul_res;
`endif

  always_comb begin
    md_stall     = md_valid_e & (state_q != S_DONE) & ~flush_e & ~i_reset & ~md_ill_raw;
    md_illegal   = md_ill_raw & ~i_reset;
    md_state_dbg = state_q;
    if (md_valid_e)
      alu_data_e = ((state_q == S_DONE) && !md_ill_raw) ? md_result : '0;
    else
      alu_data_e = alu_res;
  end

  logic unused_bits;
  assign unused_bits = ^{instr_e[31:15], instr_e[11:7], f3_q[2]};

endmodule

// File: tb/tb_ex_stage_md.sv
// ---------------------------------------------------------------------------
// tb_ex_stage_md : directed bench for ex_stage_md (XLEN = 32).
// Expected M results come from a 64-bit reference model and are queued when
// an op is driven, then popped when the DUT reports the op done.
// ---------------------------------------------------------------------------
module tb_ex_stage_md;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int NORMAL_STALL  = XLEN + 1;
  localparam int SPECIAL_STALL = 1;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic [XLEN-1:0]  pc_e;
  logic [31:0]      instr_e;
  logic [XLEN-1:0]  rs1_data_e, rs2_data_e, imm_out_e;
  logic [XLEN-1:0]  alu_data_m, wb_data_w;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             opa_sel_e, opb_sel_e, br_un_e;
  logic [3:0]       alu_op_e;
  logic             md_valid_e, flush_e;
  logic [XLEN-1:0]  alu_data_e, store_data_e;
  logic             br_taken, md_stall, md_illegal;
  logic [1:0]       md_state_dbg;

  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] exp_q[$];

  ex_stage_md #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .pc_e         (pc_e),
    .instr_e      (instr_e),
    .rs1_data_e   (rs1_data_e),
    .rs2_data_e   (rs2_data_e),
    .imm_out_e    (imm_out_e),
    .alu_data_m   (alu_data_m),
    .wb_data_w    (wb_data_w),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .opa_sel_e    (opa_sel_e),
    .opb_sel_e    (opb_sel_e),
    .br_un_e      (br_un_e),
    .alu_op_e     (alu_op_e),
    .md_valid_e   (md_valid_e),
    .flush_e      (flush_e),
    .alu_data_e   (alu_data_e),
    .store_data_e (store_data_e),
    .br_taken     (br_taken),
    .md_stall     (md_stall),
    .md_illegal   (md_illegal),
    .md_state_dbg (md_state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- helpers ----------------
  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [6:0] opc);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  function automatic logic [31:0] md_model(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb, sbu, sp;
    logic [63:0]        ua, ub, up;
    logic signed [31:0] a_s, b_s;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    sbu = {32'd0, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    a_s = a;
    b_s = b;
    case (f3)
      3'b000: begin sp = sa * sb;  return sp[31:0];  end
      3'b001: begin sp = sa * sb;  return sp[63:32]; end
      3'b010: begin sp = sa * sbu; return sp[63:32]; end
      3'b011: begin up = ua * ub;  return up[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return a_s / b_s;
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return a_s % b_s;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // ---------------- scoreboard / checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    pc_e       = '0;
    instr_e    = 32'h0000_0013;
    rs1_data_e = '0;
    rs2_data_e = '0;
    imm_out_e  = '0;
    alu_data_m = '0;
    wb_data_w  = '0;
    fwd_a_sel  = 2'b00;
    fwd_b_sel  = 2'b00;
    opa_sel_e  = 1'b0;
    opb_sel_e  = 1'b0;
    br_un_e    = 1'b0;
    alu_op_e   = 4'd0;
    md_valid_e = 1'b0;
    flush_e    = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after the op left EX.
  task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall);
    int n;
    instr_e    = mk_instr(f3, 7'b0110011);
    rs1_data_e = a;
    rs2_data_e = b;
    fwd_a_sel  = 2'b00;
    fwd_b_sel  = 2'b00;
    flush_e    = 1'b0;
    md_valid_e = 1'b1;
    exp_q.push_back(md_model(f3, a, b));
    #1;
    chk({tag, "_start_idle"}, 32'(md_state_dbg), 32'(S_IDLE));
    n = 0;
    while (md_stall === 1'b1 && n < 200) begin
      n++;
      @(negedge i_clk);
    end
    chk({tag, "_stall_cycles"}, n, exp_stall);
    chk({tag, "_done_state"}, 32'(md_state_dbg), 32'(S_DONE));
    chk({tag, "_result"}, alu_data_e, exp_q.pop_front());
    @(negedge i_clk);
    md_valid_e = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] ra, rb;
    idle_inputs();

    // Reset with an M op pending: stall and illegal must stay low.
    i_reset    = 1'b1;
    md_valid_e = 1'b1;
    instr_e    = mk_instr(3'b101, 7'b0110011);
    #1;
    chk("rst_stall", 32'(md_stall), 32'd0);
    chk("rst_illegal", 32'(md_illegal), 32'd0);
    chk("rst_state", 32'(md_state_dbg), 32'(S_IDLE));
    repeat (2) @(negedge i_clk);
    idle_inputs();
    i_reset = 1'b0;
    @(negedge i_clk);

    // Forwarding into the ALU.
    rs1_data_e = 32'd5;  alu_data_m = 32'd7;  rs2_data_e = 32'd3;
    fwd_a_sel  = 2'b01;  alu_op_e   = 4'd0;
    #1;
    chk("fwd_a_mem_add", alu_data_e, 32'd10);
    fwd_a_sel = 2'b10;  wb_data_w = 32'd1;
    #1;
    chk("fwd_a_wb_add", alu_data_e, 32'd4);
    fwd_b_sel = 2'b01;
    #1;
    chk("store_fwd_mem", store_data_e, 32'd7);
    fwd_a_sel = 2'b11;  fwd_b_sel = 2'b11;
    #1;
    chk("fwd_sel11_regfile", alu_data_e, 32'd8);
    opa_sel_e = 1'b1;  opb_sel_e = 1'b1;  pc_e = 32'h100;  imm_out_e = 32'h10;
    alu_op_e  = 4'd1;
    #1;
    chk("pc_imm_sub", alu_data_e, 32'h0F0);
    @(negedge i_clk);
    idle_inputs();

    // Branch resolution on forwarded operands.
    instr_e    = mk_instr(3'b100, 7'b1100011);
    rs1_data_e = 32'hFFFF_FFFF;  rs2_data_e = 32'd1;
    #1;
    chk("blt_signed", 32'(br_taken), 32'd1);
    instr_e = mk_instr(3'b110, 7'b1100011);  br_un_e = 1'b1;
    #1;
    chk("bltu_unsigned", 32'(br_taken), 32'd0);
    instr_e = mk_instr(3'b000, 7'b1100011);  br_un_e = 1'b0;
    #1;
    chk("beq_ne", 32'(br_taken), 32'd0);
    fwd_b_sel = 2'b10;  wb_data_w = 32'hFFFF_FFFF;
    #1;
    chk("beq_fwd_eq", 32'(br_taken), 32'd1);
    instr_e = mk_instr(3'b000, 7'b1101111);
    #1;
    chk("jal_taken", 32'(br_taken), 32'd1);
    instr_e = mk_instr(3'b000, 7'b0110011);
    #1;
    chk("rtype_not_branch", 32'(br_taken), 32'd0);
    @(negedge i_clk);
    idle_inputs();

    // Multiply, including back-to-back ops with no bubble.
    run_md("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, NORMAL_STALL);
    run_md("mul_6x7",  3'b000, 32'd6, 32'd7, NORMAL_STALL);
    run_md("mul_neg",  3'b000, 32'hFFFF_FFFD, 32'd5, NORMAL_STALL);
    ra = $urandom_range(32'hFFFF_FFFF, 0);
    rb = $urandom_range(32'hFFFF_FFFF, 0);
    run_md("mulhsu_rnd", 3'b010, ra, rb, NORMAL_STALL);
    ra = $urandom_range(32'hFFFF_FFFF, 0);
    rb = $urandom_range(32'hFFFF_FFFF, 0);
    run_md("mulhu_rnd", 3'b011, ra, rb, NORMAL_STALL);

    // Flush part way through CALC, then a fresh op.
    instr_e    = mk_instr(3'b000, 7'b0110011);
    rs1_data_e = 32'd5;  rs2_data_e = 32'd5;  md_valid_e = 1'b1;
    repeat (11) @(negedge i_clk);
    chk("flush_pre_calc", 32'(md_state_dbg), 32'(S_CALC));
    flush_e = 1'b1;
    #1;
    chk("flush_stall_low", 32'(md_stall), 32'd0);
    @(negedge i_clk);
    chk("flush_to_idle", 32'(md_state_dbg), 32'(S_IDLE));
    run_md("mul_after_flush", 3'b000, 32'd3, 32'd4, NORMAL_STALL);

`ifdef RV_M_DIV_EN
    run_md("div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'd2, NORMAL_STALL);
    run_md("rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'd2, NORMAL_STALL);
    run_md("divu_by0",  3'b101, 32'd7, 32'd0, SPECIAL_STALL);
    run_md("rem_by0",   3'b110, 32'hFFFF_FFF9, 32'd0, SPECIAL_STALL);
    run_md("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, SPECIAL_STALL);
    run_md("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, SPECIAL_STALL);
    ra = $urandom_range(32'hFFFF_FFFF, 0);
    rb = $urandom_range(32'h0000_FFFF, 1);
    run_md("remu_rnd",  3'b111, ra, rb, NORMAL_STALL);
`else
    instr_e    = mk_instr(3'b101, 7'b0110011);
    rs1_data_e = 32'd7;  rs2_data_e = 32'd3;  md_valid_e = 1'b1;
    #1;
    chk("divu_illegal", 32'(md_illegal), 32'd1);
    chk("divu_result0", alu_data_e, 32'd0);
    chk("divu_no_stall", 32'(md_stall), 32'd0);
    @(negedge i_clk);
    chk("divu_stays_idle", 32'(md_state_dbg), 32'(S_IDLE));
    md_valid_e = 1'b0;
    #1;
    chk("illegal_clears", 32'(md_illegal), 32'd0);
    @(negedge i_clk);
`endif

    // Asynchronous reset in the middle of CALC.
    instr_e    = mk_instr(3'b000, 7'b0110011);
    rs1_data_e = 32'd9;  rs2_data_e = 32'd11;  md_valid_e = 1'b1;
    repeat (6) @(negedge i_clk);
    #2;
    i_reset = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(md_stall), 32'd0);
    chk("rst_mid_state", 32'(md_state_dbg), 32'(S_IDLE));
    @(negedge i_clk);
    md_valid_e = 1'b0;
    i_reset    = 1'b0;
    @(negedge i_clk);
    run_md("mul_after_rst", 3'b000, 32'd6, 32'd7, NORMAL_STALL);

    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so a wedged run still ends with a report.
  initial begin
    #200000;
    bad++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
